// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//
// Execute-stage branch resolver. Accepts one conditional branch at a time,
// decodes funct3 against the ALU flags of the A - B compare, checks the result
// against the fetch prediction and, on a mispredict, sends a corrected fetch PC
// to fetch followed by a one-cycle flush pulse.
//
// Handshakes: a transfer happens on a rising clk edge where both valid and
// ready are high. A valid that has been raised stays high, with its payload
// unchanged, until that transfer. Ready may change freely.
//
// Optional feature: define BRU_STATS_EN to add the branch_cnt / mispred_cnt
// statistics counters and their ports. Without it, they are absent.
//
// Parameters:
//   n            datapath / PC width (default 32)
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active-low
//   in_valid     branch presented          in_ready     unit can accept
//   funct3       RV32 branch funct3
//   Zflag/Vflag/Sflag/Cflag   flags of A - B (Cflag=1 iff A >= B unsigned)
//   pc           branch instruction PC     imm          sign-extended offset
//   pred_taken   fetch prediction
//   redir_valid  redirect request          redir_ready  fetch accepts redirect
//   redir_pc     corrected fetch PC        flush        one-cycle squash pulse
//   branch_cnt   resolved branches         (BRU_STATS_EN only)
//   mispred_cnt  mispredicted branches     (BRU_STATS_EN only)
//   dbg_state    current FSM state (0 IDLE, 1 EVAL, 2 REDIRECT)
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   funct3,
    input  logic         Zflag,
    input  logic         Vflag,
    input  logic         Sflag,
    input  logic         Cflag,
    input  logic [n-1:0] pc,
    input  logic [n-1:0] imm,
    input  logic         pred_taken,
    output logic         redir_valid,
    input  logic         redir_ready,
    output logic [n-1:0] redir_pc,
    output logic         flush,
`ifdef BRU_STATS_EN
    output logic [31:0]  branch_cnt,
    output logic [31:0]  mispred_cnt,
`endif
    output logic [1:0]   dbg_state
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_EVAL     = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;

    logic [1:0]   state_q, state_d;
    logic         alive_q;
    logic [2:0]   funct3_q;
    logic         z_q, v_q, s_q, c_q;
    logic [n-1:0] pc_q, imm_q;
    logic         pred_q;
    logic         redir_valid_q, redir_valid_d;
    logic [n-1:0] redir_pc_q, redir_pc_d;
    logic         flush_q, flush_d;

    logic         taken;
    logic         mispredict;
    logic         accept;
    logic [n-1:0] target;

    // Taken decode on the captured flags; 010/011 are illegal and never taken.
    always_comb begin
        taken = 1'b0;
        case (funct3_q)
            3'b000:  taken = z_q;
            3'b001:  taken = ~z_q;
            3'b100:  taken = s_q ^ v_q;
            3'b101:  taken = ~(s_q ^ v_q);
            3'b110:  taken = ~c_q;
            3'b111:  taken = c_q;
            default: taken = 1'b0;
        endcase
    end

    assign mispredict = (state_q == ST_EVAL) && (taken != pred_q);
    // Sums wrap modulo 2^n by construction.
    assign target     = taken ? (pc_q + imm_q) : (pc_q + n'(4));

    // alive_q keeps in_ready low until the first clock after reset release.
    assign in_ready = alive_q &&
                      ((state_q == ST_IDLE) || ((state_q == ST_EVAL) && !mispredict));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d       = state_q;
        redir_valid_d = redir_valid_q;
        redir_pc_d    = redir_pc_q;
        flush_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_EVAL;
            end
            ST_EVAL: begin
                if (mispredict) begin
                    state_d       = ST_REDIRECT;
                    redir_valid_d = 1'b1;
                    redir_pc_d    = target;
                end else if (accept) begin
                    state_d = ST_EVAL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REDIRECT: begin
                if (redir_valid_q && redir_ready) begin
                    state_d       = ST_IDLE;
                    redir_valid_d = 1'b0;
                    flush_d       = 1'b1;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                redir_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            alive_q       <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            flush_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            alive_q       <= 1'b1;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            flush_q       <= flush_d;
        end
    end

    // Captured branch entry; only loaded on an input transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            funct3_q <= '0;
            z_q      <= 1'b0;
            v_q      <= 1'b0;
            s_q      <= 1'b0;
            c_q      <= 1'b0;
            pc_q     <= '0;
            imm_q    <= '0;
            pred_q   <= 1'b0;
        end else if (accept) begin
            funct3_q <= funct3;
            z_q      <= Zflag;
            v_q      <= Vflag;
            s_q      <= Sflag;
            c_q      <= Cflag;
            pc_q     <= pc;
            imm_q    <= imm;
            pred_q   <= pred_taken;
        end
    end

`ifdef BRU_STATS_EN
    logic [31:0] branch_cnt_q, mispred_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else if (state_q == ST_EVAL) begin
            branch_cnt_q <= branch_cnt_q + 32'd1;
            if (mispredict) mispred_cnt_q <= mispred_cnt_q + 32'd1;
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;
`endif

    assign redir_valid = redir_valid_q;
    assign redir_pc    = redir_pc_q;
    assign flush       = flush_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// Bench for branch_resolve_unit. Branch operands A/B are generated, flags are
// derived from A - B, and the reference decides taken/not-taken by comparing
// A and B directly. Expected redirect PCs go into exp_q; a monitor pops them
// on every redirect transfer and also tracks the flush pulse that follows.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  funct3 = 3'd0;
  logic        Zflag = 1'b0, Vflag = 1'b0, Sflag = 1'b0, Cflag = 1'b0;
  logic [31:0] pc = 32'd0, imm = 32'd0;
  logic        pred_taken = 1'b0;
  logic        redir_valid;
  logic        redir_ready = 1'b0;
  logic [31:0] redir_pc;
  logic        flush;
  logic [1:0]  dbg_state;
`ifdef BRU_STATS_EN
  logic [31:0] branch_cnt, mispred_cnt;
`endif

  branch_resolve_unit #(.n(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .funct3     (funct3),
    .Zflag      (Zflag),
    .Vflag      (Vflag),
    .Sflag      (Sflag),
    .Cflag      (Cflag),
    .pc         (pc),
    .imm        (imm),
    .pred_taken (pred_taken),
    .redir_valid(redir_valid),
    .redir_ready(redir_ready),
    .redir_pc   (redir_pc),
    .flush      (flush),
`ifdef BRU_STATS_EN
    .branch_cnt (branch_cnt),
    .mispred_cnt(mispred_cnt),
`endif
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / redirect-ready driver ----------------
  always #5 clk = ~clk;

  int rdy_mode = 0;  // 0: hold low, 1: hold high, 2: random
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0: redir_ready = 1'b0;
      1: redir_ready = 1'b1;
      default: redir_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int tests_run = 0;
  int fail_cnt  = 0;
  int exp_branch = 0;
  int exp_mis    = 0;
  int flush_cnt  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, want);
    end
  endtask

  // Reference decision straight from the operands.
  function automatic logic model_taken(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) <  $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a <  b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // ---------------- monitor ----------------
  logic flush_exp = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      flush_exp = 1'b0;
    end else begin
      if (flush) flush_cnt++;
      if (flush || flush_exp) begin
        check("flush_pulse", 32'(flush), 32'(flush_exp));
        if (flush_exp) check("ready_in_flush_cycle", 32'(in_ready), 32'd1);
      end
      flush_exp = 1'b0;
      if (redir_valid && redir_ready) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          fail_cnt++;
          $display("FAIL unexpected_redirect: got redir_pc=0x%08h, required no redirect", redir_pc);
        end else begin
          logic [31:0] want;
          want = exp_q.pop_front();
          check("redir_pc", redir_pc, want);
        end
        flush_exp = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 right after the transfer edge.
  task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] pc_v, input logic [31:0] imm_v, input logic pred,
                      output int waited);
    logic [31:0] diff;
    logic        tk;
    diff       = a - b;
    funct3     = f;
    Zflag      = (diff == 32'd0);
    Sflag      = diff[31];
    Vflag      = (a[31] ^ b[31]) & (a[31] ^ diff[31]);
    Cflag      = (a >= b);
    pc         = pc_v;
    imm        = imm_v;
    pred_taken = pred;
    in_valid   = 1'b1;
    waited     = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 100) break;
    end
    if (waited > 100) begin
      check("send_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    tk = model_taken(f, a, b);
    exp_branch++;
    if (tk != pred) begin
      exp_mis++;
      exp_q.push_back(tk ? (pc_v + imm_v) : (pc_v + 32'd4));
    end
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !redir_valid && !flush && dbg_state == 2'd0) break;
    end
    if (i == 300) check("idle_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_redir();
    int i;
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (redir_valid) break;
    end
    check("redir_valid_seen", 32'(redir_valid), 32'd1);
  endtask

  task automatic check_counters();
`ifdef BRU_STATS_EN
    check("branch_cnt", branch_cnt, 32'(exp_branch));
    check("mispred_cnt", mispred_cnt, 32'(exp_mis));
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w;
    int fbase;
    logic [2:0]  rf;
    logic [31:0] ra, rb, rpc, rimm;

    // Reset state
    repeat (3) begin
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_redir_valid", 32'(redir_valid), 32'd0);
      check("rst_redir_pc", redir_pc, 32'd0);
      check("rst_flush", 32'(flush), 32'd0);
    end
    rst = 1'b1;
    #1;
    check("ready_before_first_clk", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("ready_after_first_clk", 32'(in_ready), 32'd1);
    check_counters();

    // BEQ taken, predicted not-taken: latency and redirect to 0x120
    fbase = flush_cnt;
    send(3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0, w);
    @(negedge clk);
    check("eval_no_redir_yet", 32'(redir_valid), 32'd0);
    check("eval_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("redir_valid_latency", 32'(redir_valid), 32'd1);
    check("redir_pc_beq", redir_pc, 32'h120);
    rdy_mode = 1;
    wait_idle();
    check("beq_single_flush", 32'(flush_cnt - fbase), 32'd1);
    check_counters();

    // BLT taken and predicted taken, 4 back-to-back
    fbase = flush_cnt;
    for (int k = 0; k < 4; k++) begin
      send(3'b100, 32'hFFFFFFFD, 32'd2, 32'h200 + 32'(k * 4), 32'h40, 1'b1, w);
      check("b2b_no_stall", 32'(w), 32'd0);
    end
    wait_idle();
    check("b2b_no_flush", 32'(flush_cnt - fbase), 32'd0);
    check_counters();

    // BGEU not taken, predicted taken, pc+4 wraps to 0
    send(3'b111, 32'd0, 32'd1, 32'hFFFFFFFC, 32'h10, 1'b1, w);
    wait_idle();

    // Redirect backpressure for 5 cycles with an ignored in_valid pulse
    rdy_mode = 0;
    fbase = flush_cnt;
    send(3'b001, 32'd7, 32'd7, 32'h300, 32'h10, 1'b1, w);
    wait_redir();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) begin
        funct3 = 3'b000; Zflag = 1'b1; pred_taken = 1'b0;
        pc = 32'h500; imm = 32'h8; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      check("bp_redir_valid", 32'(redir_valid), 32'd1);
      check("bp_redir_pc", redir_pc, 32'h304);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rdy_mode = 1;
    wait_idle();
    check("bp_single_flush", 32'(flush_cnt - fbase), 32'd1);
    check_counters();

    // Illegal funct3 forced not-taken
    send(3'b010, 32'd3, 32'd3, 32'h40, 32'h100, 1'b1, w);
    send(3'b011, 32'd1, 32'd9, 32'h80, 32'h100, 1'b1, w);
    wait_idle();
    check_counters();

    // Reset asserted while in REDIRECT
    rdy_mode = 0;
    send(3'b110, 32'd0, 32'd1, 32'h600, 32'h8, 1'b0, w);
    wait_redir();
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_redir_valid", 32'(redir_valid), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    exp_branch = 0;
    exp_mis    = 0;
    fbase      = flush_cnt;
    rdy_mode   = 1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("no_flush_after_rst", 32'(flush_cnt - fbase), 32'd0);
    check_counters();
    @(posedge clk);
    #1;
    send(3'b000, 32'd9, 32'd9, 32'h700, 32'h30, 1'b0, w);
    wait_idle();
    check_counters();

    // Randomized traffic with random redirect backpressure
    rdy_mode = 2;
    for (int k = 0; k < 300; k++) begin
      rf   = 3'($urandom_range(0, 7));
      ra   = $urandom;
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ 32'h80000000;
        2: rb = ra + 32'($urandom_range(0, 2)) - 32'd1;
        default: rb = $urandom;
      endcase
      rpc  = $urandom & 32'hFFFFFFFC;
      rimm = $urandom;
      send(rf, ra, rb, rpc, rimm, 1'($urandom_range(0, 1)), w);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    rdy_mode = 1;
    wait_idle();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check_counters();

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
